ntt_butterfly_stage: RTL and testbench
======================================

Name: ntt_butterfly_stage

Overview:
- Pipelined radix-2 butterfly array directly downstream of the pre-processing unit.
- Each transfer consumes the 8 coefficients the pre-processing unit presents (out1..out8, taken as 4 pairs (1,2),(3,4),(5,6),(7,8)) plus 4 twiddles, and produces 8 mod-q results.
- NTT mode uses Cooley-Tukey butterflies; INTT mode uses Gentleman-Sande butterflies.
- Counts groups and pulses a layer-done flag after every 32 groups (256 coefficients).

Parameters:
- Q, 3329, modulus (Kyber).
- W, 12, coefficient width.
- BARRETT_M, 5039, floor(2^24/Q).
- GROUPS, 32, groups per layer (256/8).

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- in_valid  in  1  in1..in8/tw1..tw4/NTT_INTT_sel valid this cycle
- in_ready  out  1  stage accepts this cycle
- NTT_INTT_sel  in  1  1 = NTT (CT), 0 = INTT (GS); sampled with the data
- in1..in8  in  12 each  coefficients; pair k = (in(2k-1), in(2k))
- tw1..tw4  in  12 each  twiddle for pair k
- out_valid  out  1  out1..out8 valid
- out_ready  in  1  downstream accepts
- out1..out8  out  12 each  results, same pair positions as inputs
- group_cnt  out  5  groups emitted in current layer
- layer_done  out  1  one-cycle pulse on emission of group GROUPS-1

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits 0, out1..out8=0, out_valid=0, group_cnt=0, layer_done=0. Reset mid-operation discards all in-flight data. There is no partial flush.
- Pipeline: 4 register stages, so latency is 4 cycles from accepted input to out_valid. Throughput is one group per cycle.
  - S1 registers operands. In INTT mode it forms s=(a+b) mod Q and d=(a-b) mod Q.
  - S2 forms product p = w*b (NTT) or w*d (INTT), 24 bits.
  - S3 computes Barrett qhat = (p*BARRETT_M)>>24 and r = p - qhat*Q (r < 3Q).
  - S4 applies up to two conditional subtracts of Q, then the final add/sub, and registers out1..out8.
- Arithmetic:
  - NTT: a' = (a + w*b) mod Q; b' = (a - w*b) mod Q.
  - INTT: a' = (a + b) mod Q; b' = w*(a - b) mod Q. No scaling by 1/2; the final n^-1 scaling happens elsewhere.
  - Every modular add/sub is a single conditional correction. All results are in [0, Q-1].
- Operand contract: inputs and twiddles must be < Q. Values ≥ Q are out of contract and produce undefined results.
- The mode bit travels with its data. Mixed modes in flight are legal and each group uses its own sampled mode.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - A transfer occurs when in_valid & in_ready.
  - When advance=0 the entire pipeline holds, and outputs stay stable until accepted.
  - Bubbles propagate as valid=0.
- Counter:
  - group_cnt increments on each output transfer (out_valid & out_ready).
  - On the transfer of count GROUPS-1 it wraps to 0 and layer_done=1 for that single cycle (registered, visible the following cycle).
  - A stall does not re-pulse layer_done.
- Inputs with in_valid=0 are ignored regardless of value.

Decomposition:
- Shared package `ntt_pkg`: Q, W, BARRETT_M, GROUPS, mode encoding (NTT=1/INTT=0), and mod_add/mod_sub functions.
- Sub-module `mod_mult_barrett`: 12x12 multiply plus Barrett reduction, 2 pipeline registers, with an enable input.
  - Instantiated 4 times, once per pair.
  - Top level holds operand staging, add/sub, handshake and counter.

Test Plan:
- Reset, then NTT pair (1,2), w=17, remaining pairs 0 and w=0 -> 4 cycles later out1=35, out2=3296, others 0; out_valid for exactly 1 cycle.
- INTT pair (35,3296), w=1 -> out1=2, out2=68 after 4 cycles. Back-to-back NTT then INTT groups each get the correct mode.
- Extremes: NTT a=b=w=3328 on all pairs -> all odd outputs 0, all even outputs 3327. Random 10k vectors match a reference model with results always < 3329.
- Backpressure: stream 8 groups and hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the hold, no loss or duplication, output order preserved, outputs stable while stalled.
- Counter: 64 consecutive groups -> layer_done pulses at the 32nd and 64th transfers only; group_cnt reads 0 after each.
- Drop rst to 0 for 1 cycle with 3 groups in flight -> out_valid=0 and group_cnt=0 immediately with no clock needed. No stale outputs after release; the next group emerges with 4-cycle latency.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants, mode encoding and modular add/sub helpers for the Kyber NTT datapath.
package ntt_pkg;

  localparam int unsigned Q         = 3329;
  localparam int unsigned W         = 12;
  localparam int unsigned BARRETT_M = 5039;
  localparam int unsigned GROUPS    = 32;
  // Barrett remainder width; the unreduced remainder is below 3Q.
  localparam int unsigned RW        = W + 2;

  typedef enum logic {
    ModeIntt = 1'b0,
    ModeNtt  = 1'b1
  } mode_e;

  typedef logic [W-1:0] coef_t;

  function automatic coef_t mod_add(input coef_t a, input coef_t b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (W+1)'(Q)) s = s - (W+1)'(Q);
    return coef_t'(s);
  endfunction

  function automatic coef_t mod_sub(input coef_t a, input coef_t b);
    logic [W:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, a} + (W+1)'(Q) - {1'b0, b};
    return coef_t'(d);
  endfunction

  function automatic coef_t reduce_3q(input logic [RW-1:0] r);
    logic [RW-1:0] v;
    v = r;
    if (v >= RW'(Q)) v = v - RW'(Q);
    if (v >= RW'(Q)) v = v - RW'(Q);
    return coef_t'(v);
  endfunction

endpackage

// File: rtl/mod_mult_barrett.sv
// 12x12 multiply then Barrett reduction to a remainder below 3Q; two register stages.
module mod_mult_barrett
  import ntt_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  coef_t         a_i,
  input  coef_t         b_i,
  output logic [RW-1:0] r_o
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned MW = PW + 13;

  logic [PW-1:0] p_d, p_q;
  logic [W:0]    qhat;
  logic [RW-1:0] r_d, r_q;

  assign p_d  = PW'(a_i) * PW'(b_i);
  assign qhat = (W+1)'((MW'(p_q) * MW'(BARRETT_M)) >> PW);
  assign r_d  = RW'(p_q - PW'(qhat) * PW'(Q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q <= '0;
      r_q <= '0;
    end else if (en_i) begin
      p_q <= p_d;
      r_q <= r_d;
    end
  end

  assign r_o = r_q;

endmodule

// File: rtl/ntt_butterfly_stage.sv
// Four-pair radix-2 butterfly pipeline (CT for NTT, GS for INTT), 4-cycle latency,
// with valid/ready flow control and a per-layer group counter.
module ntt_butterfly_stage
  import ntt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          NTT_INTT_sel,
  input  logic [W-1:0]  in1,
  input  logic [W-1:0]  in2,
  input  logic [W-1:0]  in3,
  input  logic [W-1:0]  in4,
  input  logic [W-1:0]  in5,
  input  logic [W-1:0]  in6,
  input  logic [W-1:0]  in7,
  input  logic [W-1:0]  in8,
  input  logic [W-1:0]  tw1,
  input  logic [W-1:0]  tw2,
  input  logic [W-1:0]  tw3,
  input  logic [W-1:0]  tw4,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out1,
  output logic [W-1:0]  out2,
  output logic [W-1:0]  out3,
  output logic [W-1:0]  out4,
  output logic [W-1:0]  out5,
  output logic [W-1:0]  out6,
  output logic [W-1:0]  out7,
  output logic [W-1:0]  out8,
  output logic [4:0]    group_cnt,
  output logic          layer_done
);

  localparam logic [4:0] LastGroup = 5'(GROUPS - 1);

  logic                advance;
  mode_e               mode_in;
  logic [3:0][W-1:0]   a_in, b_in, w_in;
  logic [3:0][W-1:0]   a1_d, b1_d;
  logic [3:0][W-1:0]   s1_a_q, s1_b_q, s1_w_q, s2_a_q, s3_a_q;
  mode_e               s1_mode_q, s2_mode_q, s3_mode_q;
  logic                v1_q, v2_q, v3_q, out_valid_q;
  logic [RW-1:0]       r [4];
  logic [3:0][W-1:0]   t;
  logic [7:0][W-1:0]   out_d, out_q;
  logic [4:0]          group_cnt_q;
  logic                layer_done_q;

  // Whole pipeline stalls together while an output is pending and not taken.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  assign mode_in = mode_e'(NTT_INTT_sel);
  assign a_in    = {in7, in5, in3, in1};
  assign b_in    = {in8, in6, in4, in2};
  assign w_in    = {tw4, tw3, tw2, tw1};

  // INTT forms sum/difference up front so the multiplier always sees w * (second operand).
  always_comb begin
    a1_d = '0;
    b1_d = '0;
    for (int k = 0; k < 4; k++) begin
      if (mode_in == ModeIntt) begin
        a1_d[k] = mod_add(a_in[k], b_in[k]);
        b1_d[k] = mod_sub(a_in[k], b_in[k]);
      end else begin
        a1_d[k] = a_in[k];
        b1_d[k] = b_in[k];
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_pair
    mod_mult_barrett u_mult (
      .clk_i  (clk),
      .rst_ni (rst),
      .en_i   (advance),
      .a_i    (s1_w_q[k]),
      .b_i    (s1_b_q[k]),
      .r_o    (r[k])
    );
  end

  always_comb begin
    t     = '0;
    out_d = '0;
    for (int k = 0; k < 4; k++) begin
      t[k] = reduce_3q(r[k]);
      if (s3_mode_q == ModeNtt) begin
        out_d[2*k]   = mod_add(s3_a_q[k], t[k]);
        out_d[2*k+1] = mod_sub(s3_a_q[k], t[k]);
      end else begin
        out_d[2*k]   = s3_a_q[k];
        out_d[2*k+1] = t[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_w_q      <= '0;
      s2_a_q      <= '0;
      s3_a_q      <= '0;
      s1_mode_q   <= ModeIntt;
      s2_mode_q   <= ModeIntt;
      s3_mode_q   <= ModeIntt;
      out_q       <= '0;
    end else if (advance) begin
      v1_q        <= in_valid;
      s1_a_q      <= a1_d;
      s1_b_q      <= b1_d;
      s1_w_q      <= w_in;
      s1_mode_q   <= mode_in;
      v2_q        <= v1_q;
      s2_a_q      <= s1_a_q;
      s2_mode_q   <= s1_mode_q;
      v3_q        <= v2_q;
      s3_a_q      <= s2_a_q;
      s3_mode_q   <= s2_mode_q;
      out_valid_q <= v3_q;
      if (v3_q) out_q <= out_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      group_cnt_q  <= '0;
      layer_done_q <= 1'b0;
    end else begin
      layer_done_q <= 1'b0;
      if (out_valid_q && out_ready) begin
        if (group_cnt_q == LastGroup) begin
          group_cnt_q  <= '0;
          layer_done_q <= 1'b1;
        end else begin
          group_cnt_q <= group_cnt_q + 5'd1;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign group_cnt  = group_cnt_q;
  assign layer_done = layer_done_q;
  assign {out8, out7, out6, out5, out4, out3, out2, out1} = out_q;

endmodule

// File: tb/tb_ntt_butterfly_stage.sv
// Directed-vector and scoreboard bench for ntt_butterfly_stage.
module tb_ntt_butterfly_stage;

  localparam int Q = 3329;

  typedef logic [7:0][11:0] grp_t;
  typedef struct {
    logic              mode;
    logic [3:0][11:0]  a;
    logic [3:0][11:0]  b;
    logic [3:0][11:0]  w;
    grp_t              exp;
  } vec_t;

  logic clk, rst, in_valid, in_ready, out_valid, out_ready, layer_done;
  logic NTT_INTT_sel;
  logic [3:0][11:0] drv_a, drv_b, drv_w;
  logic [11:0] out1, out2, out3, out4, out5, out6, out7, out8;
  logic [4:0]  group_cnt;
  grp_t        act, exp_cur, snap;
  grp_t        exp_q[$];
  vec_t        tbl[6];

  int   n_pass, n_total, pulses;
  logic [4:0] cnt_m;
  logic       ld_m;
  bit         ov, acc;

  assign act = {out8, out7, out6, out5, out4, out3, out2, out1};

  ntt_butterfly_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .NTT_INTT_sel (NTT_INTT_sel),
    .in1          (drv_a[0]),
    .in2          (drv_b[0]),
    .in3          (drv_a[1]),
    .in4          (drv_b[1]),
    .in5          (drv_a[2]),
    .in6          (drv_b[2]),
    .in7          (drv_a[3]),
    .in8          (drv_b[3]),
    .tw1          (drv_w[0]),
    .tw2          (drv_w[1]),
    .tw3          (drv_w[2]),
    .tw4          (drv_w[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out1         (out1),
    .out2         (out2),
    .out3         (out3),
    .out4         (out4),
    .out5         (out5),
    .out6         (out6),
    .out7         (out7),
    .out8         (out8),
    .group_cnt    (group_cnt),
    .layer_done   (layer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] want);
    n_total++;
    if (got !== want) $display("FAIL %s: got %0h want %0h", name, got, want);
    else n_pass++;
  endtask

  // Reference butterfly using plain integer modular arithmetic.
  task automatic set_model();
    int a, b, w, tt, d;
    for (int k = 0; k < 4; k++) begin
      a = int'(drv_a[k]); b = int'(drv_b[k]); w = int'(drv_w[k]);
      if (NTT_INTT_sel) begin
        tt = (w * b) % Q;
        exp_cur[2*k]   = 12'((a + tt) % Q);
        exp_cur[2*k+1] = 12'((a - tt + Q) % Q);
      end else begin
        d = (a - b + Q) % Q;
        exp_cur[2*k]   = 12'((a + b) % Q);
        exp_cur[2*k+1] = 12'((w * d) % Q);
      end
    end
  endtask

  task automatic set_rand();
    for (int k = 0; k < 4; k++) begin
      drv_a[k] = 12'($urandom_range(Q - 1));
      drv_b[k] = 12'($urandom_range(Q - 1));
      drv_w[k] = 12'($urandom_range(Q - 1));
    end
    NTT_INTT_sel = 1'($urandom_range(1));
    set_model();
  endtask

  task automatic load_vec(input int i);
    drv_a = tbl[i].a; drv_b = tbl[i].b; drv_w = tbl[i].w;
    NTT_INTT_sel = tbl[i].mode;
    exp_cur = tbl[i].exp;
  endtask

  // One clock: entered and left at a falling edge; samples 1ns after it.
  task automatic tick(input bit vld, input bit ordy, output bit ov_o, output bit acc_o);
    grp_t e;
    in_valid = vld; out_ready = ordy;
    #1;
    ov_o = out_valid;
    chk("counter", 96'({group_cnt, layer_done}), 96'({cnt_m, ld_m}));
    chk("in_ready", 96'(in_ready), 96'(!out_valid || out_ready));
    if (layer_done) pulses++;
    acc_o = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("spurious_out", 96'(exp_q.size() != 0), 96'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data", act, e);
      end
      if (cnt_m == 5'd31) begin cnt_m = 5'd0; ld_m = 1'b1; end
      else begin cnt_m = cnt_m + 5'd1; ld_m = 1'b0; end
    end else begin
      ld_m = 1'b0;
    end
    if (acc_o) exp_q.push_back(exp_cur);
    @(negedge clk);
  endtask

  task automatic send_vec(input int i);
    load_vec(i);
    tick(1'b1, 1'b1, ov, acc);
    chk("vec_accept", 96'(acc), 96'd1);
    for (int j = 1; j <= 5; j++) begin
      tick(1'b0, 1'b1, ov, acc);
      chk("latency", 96'(ov), 96'(j == 4));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1'b0, 1'b1, ov, acc);
    chk("drain_empty", 96'(exp_q.size()), 96'd0);
  endtask

  task automatic stream(input int n, input int vld_pct, input int rdy_pct);
    int  sent;
    bit  need;
    sent = 0; need = 1'b1;
    for (int c = 0; c < n * 20 && sent < n; c++) begin
      if (need) begin set_rand(); need = 1'b0; end
      tick(1'($urandom_range(99) < vld_pct), 1'($urandom_range(99) < rdy_pct), ov, acc);
      if (acc) begin sent++; need = 1'b1; end
    end
    chk("stream_sent", 96'(sent), 96'(n));
    drain();
  endtask

  initial begin
    n_pass = 0; n_total = 0; pulses = 0;
    cnt_m = '0; ld_m = 1'b0;
    tbl[0] = '{1'b1, {12'd0, 12'd0, 12'd0, 12'd1}, {12'd0, 12'd0, 12'd0, 12'd2},
               {12'd0, 12'd0, 12'd0, 12'd17},
               {12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd3296, 12'd35}};
    tbl[1] = '{1'b0, {12'd0, 12'd0, 12'd0, 12'd35}, {12'd0, 12'd0, 12'd0, 12'd3296},
               {12'd0, 12'd0, 12'd0, 12'd1},
               {12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd68, 12'd2}};
    tbl[2] = '{1'b1, {4{12'd3328}}, {4{12'd3328}}, {4{12'd3328}},
               {12'd3327, 12'd0, 12'd3327, 12'd0, 12'd3327, 12'd0, 12'd3327, 12'd0}};
    tbl[3] = '{1'b1, {12'd0, 12'd3328, 12'd1, 12'd100}, {12'd5, 12'd3328, 12'd2, 12'd200},
               {12'd1, 12'd3328, 12'd17, 12'd3000},
               {12'd3324, 12'd5, 12'd3327, 12'd0, 12'd3296, 12'd35, 12'd2649, 12'd880}};
    tbl[4] = '{1'b0, {12'd10, 12'd35, 12'd3328, 12'd5}, {12'd5, 12'd3296, 12'd3328, 12'd10},
               {12'd7, 12'd1, 12'd3328, 12'd2},
               {12'd35, 12'd15, 12'd68, 12'd2, 12'd0, 12'd3327, 12'd3319, 12'd15}};
    tbl[5] = '{1'b0, {12'd1, 12'd3328, 12'd0, 12'd3000}, {12'd3328, 12'd0, 12'd0, 12'd1000},
               {12'd3328, 12'd3328, 12'd5, 12'd0},
               {12'd3327, 12'd0, 12'd1, 12'd3328, 12'd0, 12'd0, 12'd0, 12'd671}};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drv_a = '0; drv_b = '0; drv_w = '0; NTT_INTT_sel = 1'b1; exp_cur = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 96'(out_valid), 96'd0);
    chk("rst_group_cnt", 96'(group_cnt), 96'd0);
    chk("rst_layer_done", 96'(layer_done), 96'd0);
    chk("rst_outputs", act, 96'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) send_vec(i);

    // Back-to-back groups of opposite modes.
    load_vec(0); tick(1'b1, 1'b1, ov, acc);
    load_vec(1); tick(1'b1, 1'b1, ov, acc);
    load_vec(4); tick(1'b1, 1'b1, ov, acc);
    drain();

    stream(300, 80, 75);

    // Backpressure: fill the pipe, stall 5 cycles, resume.
    for (int g = 0; g < 6; g++) begin
      set_rand();
      tick(1'b1, 1'b1, ov, acc);
      chk("bp_accept", 96'(acc), 96'd1);
    end
    snap = act;
    chk("bp_valid", 96'(out_valid), 96'd1);
    set_rand();
    for (int h = 0; h < 5; h++) begin
      tick(1'b1, 1'b0, ov, acc);
      chk("bp_in_ready", 96'(acc), 96'd0);
      chk("bp_stable", act, snap);
    end
    for (int g = 0; g < 2; g++) begin
      acc = 1'b0;
      for (int c = 0; c < 10 && !acc; c++) tick(1'b1, 1'b1, ov, acc);
      chk("bp_resume", 96'(acc), 96'd1);
      set_rand();
    end
    drain();

    // Asynchronous reset with groups in flight.
    for (int g = 0; g < 5; g++) begin
      set_rand();
      tick(1'b1, 1'b1, ov, acc);
    end
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 96'(out_valid), 96'd0);
    chk("midrst_group_cnt", 96'(group_cnt), 96'd0);
    chk("midrst_outputs", act, 96'd0);
    exp_q.delete(); cnt_m = '0; ld_m = 1'b0; pulses = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, ov, acc);
      chk("no_stale", 96'(ov), 96'd0);
    end
    send_vec(0);

    // 64 transfers since reset: layer_done must pulse exactly twice.
    stream(63, 100, 100);
    tick(1'b0, 1'b1, ov, acc);
    chk("layer_pulses", 96'(pulses), 96'd2);
    chk("final_group_cnt", 96'(group_cnt), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
